banked_request_router: RTL and testbench

- Parametrised successor to the combinational global-to-bank address split.
- Accepts NR requester ports with valid/ready handshake and decodes each global address into bank select plus local address, in word-interleave or block-interleave mode.
- Arbitrates per bank with round-robin, drives registered bank strobes, and returns fixed-latency read data to the issuing requester.
- Sits between compute clients (systolic array feeders, DMA) and the SRAM bank array.

---
 rtl/banked_request_router.sv | 170 +++++++++++++++++
 tb/tb_banked_request_router.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_request_router.sv
// Routes NR requesters onto NB interleaved SRAM banks: address decode, per-bank
// round-robin arbitration, registered bank strobes and fixed-latency read return.
module banked_request_router #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int NB       = 4,
    parameter int NR       = 2,
    parameter int BLK_BITS = 2,
    parameter int READ_LAT = 1,
    localparam int BANK_BITS = $clog2(NB),
    localparam int LOCAL_W   = ADDR_W - BANK_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_mode,
    input  logic [NR-1:0]        req_valid,
    output logic [NR-1:0]        req_ready,
    input  logic [NR-1:0]        req_we,
    input  logic [NR*ADDR_W-1:0] req_addr,
    input  logic [NR*DATA_W-1:0] req_wdata,
    output logic [NR-1:0]        resp_valid,
    output logic [NR*DATA_W-1:0] resp_rdata,
    output logic [NB-1:0]        bank_en,
    output logic [NB-1:0]        bank_we,
    output logic [NB*LOCAL_W-1:0] bank_addr,
    output logic [NB*DATA_W-1:0] bank_wdata,
    input  logic [NB*DATA_W-1:0] bank_rdata,
    output logic [15:0]          stall_count
);

    localparam int ID_W = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((64'd1 << BLK_BITS) - 64'd1);

    function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_W-1:0] a, input logic mode);
        return mode ? BANK_BITS'(a >> BLK_BITS) : a[BANK_BITS-1:0];
    endfunction

    // Block mode squeezes the bank field out of the middle of the address.
    function automatic logic [LOCAL_W-1:0] local_of(input logic [ADDR_W-1:0] a, input logic mode);
        if (mode)
            return LOCAL_W'(((a >> (BLK_BITS + BANK_BITS)) << BLK_BITS) | (a & BLK_MASK));
        return LOCAL_W'(a >> BANK_BITS);
    endfunction

    logic [BANK_BITS-1:0] dec_bank  [NR];
    logic [LOCAL_W-1:0]   dec_local [NR];

    logic [NR-1:0]       grant;
    logic [NB-1:0]       gnt_vld;
    logic [ID_W-1:0]     gnt_id    [NB];
    logic [NB-1:0]       win_we;
    logic [LOCAL_W-1:0]  win_local [NB];
    logic [DATA_W-1:0]   win_wdata [NB];
    logic [ID_W-1:0]     ptr_q     [NB];
    logic [ID_W-1:0]     ptr_d     [NB];

    logic [NB-1:0]         bank_en_q;
    logic [NB-1:0]         bank_we_q;
    logic [NB*LOCAL_W-1:0] bank_addr_q;
    logic [NB*DATA_W-1:0]  bank_wdata_q;

    logic [READ_LAT:0]   pipe_vld_q [NB];
    logic [ID_W-1:0]     pipe_id_q  [NB][READ_LAT+1];

    logic [NR-1:0]        resp_valid_q, resp_valid_d;
    logic [NR*DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [15:0]          stall_q, stall_d;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            dec_bank[i]  = bank_of(req_addr[i*ADDR_W +: ADDR_W], cfg_mode);
            dec_local[i] = local_of(req_addr[i*ADDR_W +: ADDR_W], cfg_mode);
        end
    end

    // Round-robin: scan requesters starting at ptr[b], first candidate wins.
    always_comb begin
        grant   = '0;
        gnt_vld = '0;
        win_we  = '0;
        for (int b = 0; b < NB; b++) begin
            gnt_id[b]    = '0;
            win_local[b] = '0;
            win_wdata[b] = '0;
            ptr_d[b]     = ptr_q[b];
        end
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < NR; k++) begin
                for (int i = 0; i < NR; i++) begin
                    if (!gnt_vld[b] && i == ((int'(ptr_q[b]) + k) % NR) &&
                        req_valid[i] && dec_bank[i] == BANK_BITS'(b)) begin
                        gnt_vld[b]   = 1'b1;
                        gnt_id[b]    = ID_W'(i);
                        grant[i]     = 1'b1;
                        win_we[b]    = req_we[i];
                        win_local[b] = dec_local[i];
                        win_wdata[b] = req_wdata[i*DATA_W +: DATA_W];
                        ptr_d[b]     = ID_W'((i + 1) % NR);
                    end
                end
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        stall_d = stall_q;
        if (|(req_valid & ~grant) && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_comb begin
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NR; i++) begin
                if (pipe_vld_q[b][READ_LAT] && pipe_id_q[b][READ_LAT] == ID_W'(i)) begin
                    resp_valid_d[i]                 = 1'b1;
                    resp_rdata_d[i*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_en_q    <= '0;
            bank_we_q    <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            stall_q      <= '0;
            for (int b = 0; b < NB; b++) begin
                ptr_q[b]      <= '0;
                pipe_vld_q[b] <= '0;
                for (int s = 0; s <= READ_LAT; s++)
                    pipe_id_q[b][s] <= '0;
            end
        end else begin
            bank_en_q    <= gnt_vld;
            bank_we_q    <= gnt_vld & win_we;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            stall_q      <= stall_d;
            for (int b = 0; b < NB; b++) begin
                ptr_q[b] <= ptr_d[b];
                if (gnt_vld[b]) begin
                    bank_addr_q[b*LOCAL_W +: LOCAL_W] <= win_local[b];
                    bank_wdata_q[b*DATA_W +: DATA_W]  <= win_wdata[b];
                end
                // Stage 0 lines up with bank_en; stage READ_LAT with bank_rdata.
                pipe_vld_q[b]   <= {pipe_vld_q[b][READ_LAT-1:0], gnt_vld[b] & ~win_we[b]};
                pipe_id_q[b][0] <= gnt_id[b];
                for (int s = 1; s <= READ_LAT; s++)
                    pipe_id_q[b][s] <= pipe_id_q[b][s-1];
            end
        end
    end

    assign bank_en     = bank_en_q;
    assign bank_we     = bank_we_q;
    assign bank_addr   = bank_addr_q;
    assign bank_wdata  = bank_wdata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_banked_request_router.sv
// Directed bench for banked_request_router: decode/arbitration vector table plus
// hand-written conflict, reset-in-flight and counter saturation sequences.
module tb_banked_request_router;

    localparam int ADDR_W = 16, DATA_W = 32, NB = 4, NR = 2, BLK_BITS = 2, READ_LAT = 1;
    localparam int LOCAL_W = 14;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cfg_mode;
    logic [NR-1:0]         req_valid, req_ready, req_we;
    logic [NR*ADDR_W-1:0]  req_addr;
    logic [NR*DATA_W-1:0]  req_wdata;
    logic [NR-1:0]         resp_valid;
    logic [NR*DATA_W-1:0]  resp_rdata;
    logic [NB-1:0]         bank_en, bank_we;
    logic [NB*LOCAL_W-1:0] bank_addr;
    logic [NB*DATA_W-1:0]  bank_wdata, bank_rdata;
    logic [15:0]           stall_count;

    int n_chk = 0;
    int n_fail = 0;

    banked_request_router #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NB(NB), .NR(NR),
        .BLK_BITS(BLK_BITS), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Bank model: one-cycle read returning a word tagged with bank and local address.
    function automatic logic [31:0] bank_word(input int b, input int loc);
        return 32'hA500_0000 | (32'(b) << 16) | 32'(loc);
    endfunction

    logic [DATA_W-1:0] model_q [NB];
    logic              ovr_en;
    logic [DATA_W-1:0] ovr_val;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (bank_en[b] && !bank_we[b])
                model_q[b] <= bank_word(b, int'(bank_addr[b*LOCAL_W +: LOCAL_W]));
    end

    always_comb begin
        bank_rdata = '0;
        for (int b = 0; b < NB; b++)
            bank_rdata[b*DATA_W +: DATA_W] = model_q[b];
        if (ovr_en)
            bank_rdata[2*DATA_W +: DATA_W] = ovr_val;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        mode;
        logic [1:0]  vld;
        logic [1:0]  we;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [1:0]  rdy;
        logic [3:0]  en;
        logic [3:0]  bwe;
        int          bk0;
        int          loc0;
        int          bk1;
        int          loc1;
        logic [1:0]  resp;
    } vec_t;

    vec_t vt [10];

    initial begin
        int bk, loc, r0, r1;
        logic [1:0]  exp_resp;
        logic [15:0] ca0 [4];
        logic [15:0] ca1 [4];
        logic [1:0]  crdy [4];

        vt[0] = '{1'b0, 2'b01, 2'b00, 16'h0006, 16'h0000, 2'b01, 4'b0100, 4'b0000, 2, 1,      0, 0,      2'b01};
        vt[1] = '{1'b1, 2'b01, 2'b00, 16'h0016, 16'h0000, 2'b01, 4'b0010, 4'b0000, 1, 6,      0, 0,      2'b01};
        vt[2] = '{1'b0, 2'b01, 2'b00, 16'h0016, 16'h0000, 2'b01, 4'b0100, 4'b0000, 2, 5,      0, 0,      2'b01};
        vt[3] = '{1'b0, 2'b11, 2'b01, 16'h0010, 16'h0021, 2'b11, 4'b0011, 4'b0001, 0, 4,      1, 8,      2'b10};
        vt[4] = '{1'b0, 2'b11, 2'b00, 16'h0003, 16'h0007, 2'b01, 4'b1000, 4'b0000, 3, 0,      3, 1,      2'b01};
        vt[5] = '{1'b0, 2'b11, 2'b00, 16'h0003, 16'h0007, 2'b10, 4'b1000, 4'b0000, 3, 0,      3, 1,      2'b10};
        vt[6] = '{1'b1, 2'b11, 2'b11, 16'h0000, 16'h0004, 2'b11, 4'b0011, 4'b0011, 0, 0,      1, 0,      2'b00};
        vt[7] = '{1'b1, 2'b10, 2'b00, 16'h0000, 16'h00FF, 2'b10, 4'b1000, 4'b0000, 0, 0,      3, 16'h3F, 2'b10};
        vt[8] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 4'b0000, 4'b0000, 0, 0,      0, 0,      2'b00};
        vt[9] = '{1'b0, 2'b11, 2'b00, 16'hFFFF, 16'h8000, 2'b11, 4'b1001, 4'b0000, 3, 16'h3FFF, 0, 16'h2000, 2'b11};

        ca0  = '{16'h0003, 16'h000B, 16'h000B, 16'h0013};
        ca1  = '{16'h0007, 16'h0007, 16'h000F, 16'h000F};
        crdy = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n = 1'b0; cfg_mode = 1'b0; req_valid = '0; req_we = '0;
        req_addr = '0; req_wdata = '0; ovr_en = 1'b0; ovr_val = '0;
        repeat (2) tick();
        chk("rst_bank_en", 64'(bank_en), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_stall", 64'(stall_count), 64'h0);
        chk("rst_ready", 64'(req_ready), 64'h0);
        rst_n = 1'b1;

        // Single read with a forced bank return value.
        tick();
        cfg_mode = 1'b0; req_valid = 2'b01; req_we = 2'b00; req_addr = {16'h0000, 16'h0006};
        #1 chk("rd_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        chk("rd_bank_en", 64'(bank_en), 64'h4);
        chk("rd_bank_addr2", 64'(bank_addr[2*LOCAL_W +: LOCAL_W]), 64'h1);
        ovr_en = 1'b1; ovr_val = 32'hDEADBEEF;
        tick();
        tick();
        chk("rd_resp_valid", 64'(resp_valid), 64'h1);
        chk("rd_resp_rdata0", 64'(resp_rdata[31:0]), 64'hDEADBEEF);
        ovr_en = 1'b0;

        for (int v = 0; v < 10; v++) begin
            tick();
            cfg_mode  = vt[v].mode;
            req_valid = vt[v].vld;
            req_we    = vt[v].we;
            req_addr  = {vt[v].a1, vt[v].a0};
            req_wdata = {32'h2000_0000 + 32'(v), 32'h1000_0000 + 32'(v)};
            #1 chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vt[v].rdy));
            tick();
            req_valid = '0;
            chk($sformatf("v%0d_bank_en", v), 64'(bank_en), 64'(vt[v].en));
            chk($sformatf("v%0d_bank_we", v), 64'(bank_we), 64'(vt[v].bwe));
            for (int i = 0; i < NR; i++) begin
                bk  = (i == 0) ? vt[v].bk0 : vt[v].bk1;
                loc = (i == 0) ? vt[v].loc0 : vt[v].loc1;
                if (vt[v].rdy[i]) begin
                    chk($sformatf("v%0d_addr_r%0d", v, i), 64'(bank_addr[bk*LOCAL_W +: LOCAL_W]), 64'(loc));
                    if (vt[v].we[i])
                        chk($sformatf("v%0d_wdata_r%0d", v, i), 64'(bank_wdata[bk*DATA_W +: DATA_W]),
                            64'(((i == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(v)));
                end
            end
            tick();
            tick();
            chk($sformatf("v%0d_resp_valid", v), 64'(resp_valid), 64'(vt[v].resp));
            for (int i = 0; i < NR; i++) begin
                bk  = (i == 0) ? vt[v].bk0 : vt[v].bk1;
                loc = (i == 0) ? vt[v].loc0 : vt[v].loc1;
                if (vt[v].resp[i])
                    chk($sformatf("v%0d_rdata_r%0d", v, i), 64'(resp_rdata[i*DATA_W +: DATA_W]), 64'(bank_word(bk, loc)));
            end
        end

        // Four-cycle conflict on bank 3: grants must alternate 0,1,0,1.
        do_reset();
        cfg_mode = 1'b0;
        r0 = 0; r1 = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 4) begin
                req_valid = 2'b11; req_we = 2'b00; req_addr = {ca1[k], ca0[k]};
                #1 chk($sformatf("cf%0d_ready", k), 64'(req_ready), 64'(crdy[k]));
            end else begin
                req_valid = '0;
            end
            exp_resp = (k >= 3 && k <= 6) ? 2'(1 << ((k - 3) % 2)) : 2'b00;
            chk($sformatf("cf%0d_resp_valid", k), 64'(resp_valid), 64'(exp_resp));
            if (resp_valid[0]) r0++;
            if (resp_valid[1]) r1++;
            if (exp_resp != 2'b00)
                chk($sformatf("cf%0d_rdata", k), 64'(resp_rdata[((k - 3) % 2)*DATA_W +: DATA_W]),
                    64'(bank_word(3, k - 3)));
            if (k == 4)
                chk("cf_stall", 64'(stall_count), 64'd4);
        end
        chk("cf_resp_count_r0", 64'(r0), 64'd2);
        chk("cf_resp_count_r1", 64'(r1), 64'd2);
        chk("cf_stall_hold", 64'(stall_count), 64'd4);

        // Reset asserted while a read is in flight.
        tick();
        req_valid = 2'b01; req_we = 2'b00; req_addr = {16'h0000, 16'h0006};
        tick();
        req_valid = '0;
        chk("rf_bank_en_pre", 64'(bank_en), 64'h4);
        rst_n = 1'b0;
        #1;
        chk("rf_bank_en", 64'(bank_en), 64'h0);
        chk("rf_bank_we", 64'(bank_we), 64'h0);
        chk("rf_bank_addr", 64'(bank_addr), 64'h0);
        chk("rf_bank_wdata", 64'(|bank_wdata), 64'h0);
        chk("rf_resp_valid", 64'(resp_valid), 64'h0);
        chk("rf_resp_rdata", 64'(resp_rdata), 64'h0);
        chk("rf_stall", 64'(stall_count), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rf_post%0d_resp_valid", k), 64'(resp_valid), 64'h0);
        end

        // Long conflict to drive the stall counter into saturation.
        do_reset();
        tick();
        req_valid = 2'b11; req_we = 2'b00; req_addr = {16'h0007, 16'h0003};
        repeat (65534) tick();
        chk("sat_fffe", 64'(stall_count), 64'hFFFE);
        tick();
        chk("sat_ffff", 64'(stall_count), 64'hFFFF);
        repeat (70000 - 65535) tick();
        chk("sat_hold", 64'(stall_count), 64'hFFFF);
        req_valid = '0;
        tick();
        tick();
        chk("sat_idle", 64'(stall_count), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
